pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage controller that sequences the program counter register and the instruction-memory request port. It computes the next PC and drives the PC register's enable and next-address inputs; the PC register's output is fed back on `pc_i`. It resolves redirects from execute (trap over branch), obeys the memory request/ack handshake, and delivers fetched instructions to decode through a one-entry output register backed by a one-entry skid register.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pc_i` input 32: current PC-register value.
- `pc_en_o` output 1: PC-register load enable.
- `pc_in_o` output 32: PC-register next value.
- `imem_req_o` output 1: instruction fetch request.
- `imem_addr_o` output 32: fetch address, always equal to `pc_i`.
- `imem_ack_i` input 1: fetch complete; allowed in the same cycle `imem_req_o` rises.
- `imem_rdata_i` input 32: instruction word, valid when `imem_ack_i`=1.
- `if_valid_o` output 1: output register holds an instruction.
- `if_pc_o` output 32: PC of the held instruction.
- `if_instr_o` output 32: held instruction.
- `if_ready_i` input 1: decode accepts; a transfer occurs when `if_valid_o` and `if_ready_i` are both 1.
- `branch_taken_i` input 1: single-cycle branch/jump redirect pulse.
- `branch_target_i` input 32: branch target.
- `trap_i` input 1: single-cycle trap pulse; has priority over branch.
- `trap_vector_i` input 32: trap target.
- `misalign_o` output 1: one-cycle pulse when a misaligned target is converted to a trap (see Configuration).

## Operation
- States: BOOT, FETCH, DISCARD, HOLD.
- `slot_ok` = !`if_valid_o` or `if_ready_i`.
- `redirect` = `trap_i` or `branch_taken_i`. The target is `trap_vector_i` if `trap_i`=1, otherwise `branch_target_i`.
- BOOT:
  - `pc_en_o`=1 and `pc_in_o`=RESET_VECTOR for one cycle, then go to FETCH.
  - Redirects are ignored.
- FETCH:
  - `imem_req_o` = `req_held` or `slot_ok`.
  - `req_held` is set on req and not ack, and cleared on ack, so a raised request stays high with a stable address until ack.
  - Redirect with ack in the same cycle: drop the returned data, load the target, clear the output and skid registers, stay in FETCH.
  - Redirect while req is high without ack: latch the target into `redirect_pc`, set `pc_en_o`=0, clear the output register, go to DISCARD.
  - Redirect while req is low: load the target, clear the output and skid registers, stay in FETCH.
  - Ack with no redirect:
    - Load `pc_in_o` = `pc_i`+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0).
    - If `slot_ok`, write `imem_rdata_i`/`pc_i` into the output register.
    - Otherwise, write them into the skid register and go to HOLD.
- DISCARD:
  - Keep `imem_req_o`=1 and the address unchanged.
  - A new redirect overwrites `redirect_pc`, with trap priority.
  - On ack: drop the data, load `pc_in_o`=`redirect_pc`, go to FETCH.
- HOLD:
  - `imem_req_o`=0.
  - When `if_ready_i`=1, move the skid register into the output register and go to FETCH.
  - A redirect clears both registers, loads the target, and goes to FETCH.
- In all other cases `pc_en_o`=0.

## Timing
- Reset values: state=BOOT, `imem_req_o`=0, `pc_en_o`=0, `pc_in_o`=RESET_VECTOR, `if_valid_o`=0, `if_pc_o`=0, `if_instr_o`=0, `misalign_o`=0, `req_held`=0, skid valid=0.
- Reset asserted mid-operation clears all state at once and abandons any outstanding request; the memory is reset by the same signal.
- Cycle 1 after reset release is BOOT; the first request is in cycle 2 at RESET_VECTOR.
- With a zero-wait memory and `if_ready_i`=1: one instruction per cycle, and `if_valid_o` is asserted one cycle after ack.
- Redirect penalty: the target request is issued in the cycle after the redirect when no request is pending. Otherwise it is issued in the cycle after the pending ack.
- `pc_en_o`, `pc_in_o` and `imem_req_o` are combinational from state and inputs. The output and skid registers are registered.

## Configuration
- Macro: `PC_SEQ_MISALIGN_TRAP_EN`.
- Defined: a branch target with bits [1:0] != 0 is not taken. Instead the block redirects to `trap_vector_i` and pulses `misalign_o` in the redirect cycle. A misaligned `trap_vector_i` is forced to bits [1:0]=0.
- Undefined: bits [1:0] of every target are forced to 0, and `misalign_o` is tied to 0.

## Test plan
- Reset release, zero-wait memory, `if_ready_i`=1 → request addresses 0, 4, 8…; `if_valid_o` goes high on cycle 3 with `if_pc_o`=0.
- `if_ready_i`=0 for 3 cycles during an acked fetch → the instruction is held in skid, `imem_req_o`=0 in HOLD, and no instruction is lost or duplicated when ready returns.
- Memory with 3-cycle ack, `branch_taken_i` with target 32'h40 on the first wait cycle → DISCARD; the first ack is dropped; the next request address is 32'h40.
- `trap_i` and `branch_taken_i` in the same cycle, with `trap_vector_i`=32'h100 and branch target 32'h80 → the next fetch is at 32'h100.
- PC at 32'hFFFF_FFFC, ack → `pc_in_o`=0.
- Macro defined, branch target 32'h42 → `misalign_o` pulses and the next fetch is at `trap_vector_i`. Macro undefined → the next fetch is at 32'h40.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage sequencer: drives the PC register and instruction-memory request, delivers instructions to decode.
// Optional macro PC_SEQ_MISALIGN_TRAP_EN: misaligned branch targets become traps to trap_vector_i.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic        pc_en_o,
    output logic [31:0] pc_in_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        trap_i,
    input  logic [31:0] trap_vector_i,
    output logic        misalign_o
);

    typedef enum logic [1:0] {BOOT, FETCH, DISCARD, HOLD} state_t;

    state_t      state_reg;
    logic        req_held_reg;
    logic [31:0] redirect_pc_reg;
    logic        out_valid_reg;
    logic [31:0] out_pc_reg;
    logic [31:0] out_instr_reg;
    logic        skid_valid_reg;
    logic [31:0] skid_pc_reg;
    logic [31:0] skid_instr_reg;

    logic        slot_ok;
    logic        redirect;
    logic [31:0] target;
    logic        fetch_ack;
    logic        fetch_wait;

    assign imem_addr_o = pc_i;
    assign if_valid_o  = out_valid_reg;
    assign if_pc_o     = out_pc_reg;
    assign if_instr_o  = out_instr_reg;
    assign slot_ok     = !out_valid_reg || if_ready_i;
    assign redirect    = (state_reg != BOOT) && (trap_i || branch_taken_i);
    assign fetch_ack   = imem_req_o && imem_ack_i;
    assign fetch_wait  = imem_req_o && !imem_ack_i;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic branch_misaligned;
    assign branch_misaligned = branch_taken_i && !trap_i && (branch_target_i[1:0] != 2'b00);
    assign target     = (trap_i || branch_misaligned) ? (trap_vector_i & 32'hFFFF_FFFC)
                                                      : branch_target_i;
    assign misalign_o = redirect && branch_misaligned;
`else
    assign target     = trap_i ? (trap_vector_i & 32'hFFFF_FFFC)
                               : (branch_target_i & 32'hFFFF_FFFC);
    assign misalign_o = 1'b0;
`endif

    // PC-register controls and the fetch request are combinational so a redirect costs no extra cycle.
    always_comb begin
        imem_req_o = 1'b0;
        pc_en_o    = 1'b0;
        pc_in_o    = pc_i + 32'd4;
        case (state_reg)
            BOOT: begin
                pc_en_o = rst;
                pc_in_o = RESET_VECTOR;
            end
            FETCH: begin
                imem_req_o = req_held_reg || slot_ok;
                if (redirect) begin
                    if (!(imem_req_o && !imem_ack_i)) begin
                        pc_en_o = 1'b1;
                        pc_in_o = target;
                    end
                end else if (imem_req_o && imem_ack_i) begin
                    pc_en_o = 1'b1;
                end
            end
            DISCARD: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    pc_en_o = 1'b1;
                    pc_in_o = redirect ? target : redirect_pc_reg;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_en_o = 1'b1;
                    pc_in_o = target;
                end
            end
            default: begin
                pc_en_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= BOOT;
            req_held_reg    <= 1'b0;
            redirect_pc_reg <= 32'h0;
            out_valid_reg   <= 1'b0;
            out_pc_reg      <= 32'h0;
            out_instr_reg   <= 32'h0;
            skid_valid_reg  <= 1'b0;
            skid_pc_reg     <= 32'h0;
            skid_instr_reg  <= 32'h0;
        end else begin
            if (out_valid_reg && if_ready_i) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                BOOT: begin
                    state_reg <= FETCH;
                end
                FETCH: begin
                    if (fetch_wait) begin
                        req_held_reg <= 1'b1;
                    end else if (fetch_ack) begin
                        req_held_reg <= 1'b0;
                    end
                    if (redirect) begin
                        out_valid_reg  <= 1'b0;
                        skid_valid_reg <= 1'b0;
                        if (fetch_wait) begin
                            redirect_pc_reg <= target;
                            state_reg       <= DISCARD;
                        end
                    end else if (fetch_ack) begin
                        if (slot_ok) begin
                            out_valid_reg <= 1'b1;
                            out_pc_reg    <= pc_i;
                            out_instr_reg <= imem_rdata_i;
                        end else begin
                            skid_valid_reg <= 1'b1;
                            skid_pc_reg    <= pc_i;
                            skid_instr_reg <= imem_rdata_i;
                            state_reg      <= HOLD;
                        end
                    end
                end
                DISCARD: begin
                    // The returned word belongs to the abandoned path and is dropped.
                    if (imem_ack_i) begin
                        req_held_reg <= 1'b0;
                        state_reg    <= FETCH;
                    end else if (redirect) begin
                        redirect_pc_reg <= target;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        out_valid_reg  <= 1'b0;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= FETCH;
                    end else if (if_ready_i) begin
                        out_valid_reg  <= skid_valid_reg;
                        out_pc_reg     <= skid_pc_reg;
                        out_instr_reg  <= skid_instr_reg;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= FETCH;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a PC-register model and a variable-latency instruction memory.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_en_o;
    logic [31:0] pc_in_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        trap_i;
    logic [31:0] trap_vector_i;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;
    int mem_lat;
    int wait_cnt;
    logic [31:0] got_pc[$];
    logic [31:0] exp_pc[$];
    logic [31:0] mis_target;
    logic        mis_pulse;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_en_o(pc_en_o), .pc_in_o(pc_in_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
        .if_instr_o(if_instr_o), .if_ready_i(if_ready_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .trap_i(trap_i), .trap_vector_i(trap_vector_i),
        .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register and memory models
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_i <= 32'h0;
        else if (pc_en_o) pc_i <= pc_in_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (imem_req_o && !imem_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign imem_ack_i   = imem_req_o && (wait_cnt == mem_lat);
    assign imem_rdata_i = imem_addr_o ^ KEY;

    always @(posedge clk) begin
        if (rst && if_valid_o && if_ready_i) got_pc.push_back(if_pc_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        mis_target = 32'h200;
        mis_pulse  = 1'b1;
`else
        mis_target = 32'h40;
        mis_pulse  = 1'b0;
`endif
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h44, 32'h100, 32'h500};
        rst = 1'b0; if_ready_i = 1'b1; branch_taken_i = 1'b0; trap_i = 1'b0;
        branch_target_i = 32'h0; trap_vector_i = 32'h0; mem_lat = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req_o, 0);      chk("rst_en", pc_en_o, 0);
        chk("rst_pc_in", pc_in_o, 32'h0);   chk("rst_valid", if_valid_o, 0);
        chk("rst_if_pc", if_pc_o, 0);       chk("rst_instr", if_instr_o, 0);
        chk("rst_mis", misalign_o, 0);

        @(negedge clk); rst = 1'b1; #1;                                   // cycle 1: BOOT
        chk("boot_en", pc_en_o, 1); chk("boot_pc_in", pc_in_o, 32'h0); chk("boot_req", imem_req_o, 0);
        @(negedge clk); #1;                                               // cycle 2
        chk("c2_req", imem_req_o, 1); chk("c2_addr", imem_addr_o, 32'h0);
        chk("c2_pc_in", pc_in_o, 32'h4); chk("c2_valid", if_valid_o, 0);
        @(negedge clk); #1;                                               // cycle 3
        chk("c3_addr", imem_addr_o, 32'h4); chk("c3_valid", if_valid_o, 1);
        chk("c3_if_pc", if_pc_o, 32'h0); chk("c3_instr", if_instr_o, 32'h0 ^ KEY);
        @(negedge clk); #1;
        chk("c4_addr", imem_addr_o, 32'h8); chk("c4_if_pc", if_pc_o, 32'h4);

        for (int i = 0; i < 3; i++) begin                                 // decode stalls
            @(negedge clk); if_ready_i = 1'b0; #1;
            chk("stall_req", imem_req_o, 0); chk("stall_en", pc_en_o, 0);
            chk("stall_if_pc", if_pc_o, 32'h8);
        end
        @(negedge clk); if_ready_i = 1'b1; #1;
        chk("c8_req", imem_req_o, 1); chk("c8_addr", imem_addr_o, 32'hC); chk("c8_if_pc", if_pc_o, 32'h8);
        @(negedge clk); #1;
        chk("c9_addr", imem_addr_o, 32'h10); chk("c9_if_pc", if_pc_o, 32'hC);

        @(negedge clk); mem_lat = 2; branch_taken_i = 1'b1; branch_target_i = 32'h40; #1;
        chk("br_req", imem_req_o, 1); chk("br_addr", imem_addr_o, 32'h14);
        chk("br_en", pc_en_o, 0); chk("br_if_pc", if_pc_o, 32'h10);
        @(negedge clk); branch_taken_i = 1'b0; #1;
        chk("disc_req", imem_req_o, 1); chk("disc_addr", imem_addr_o, 32'h14);
        chk("disc_en", pc_en_o, 0); chk("disc_valid", if_valid_o, 0);
        @(negedge clk); #1;
        chk("disc_ack_en", pc_en_o, 1); chk("disc_ack_pc_in", pc_in_o, 32'h40);
        chk("disc_ack_valid", if_valid_o, 0);
        @(negedge clk); #1;
        chk("tgt_addr", imem_addr_o, 32'h40); chk("tgt_req", imem_req_o, 1); chk("tgt_en", pc_en_o, 0);
        @(negedge clk); #1;
        chk("held_req", imem_req_o, 1); chk("held_addr", imem_addr_o, 32'h40);
        @(negedge clk); #1;
        chk("tgt_ack_en", pc_en_o, 1); chk("tgt_ack_pc_in", pc_in_o, 32'h44);
        @(negedge clk); mem_lat = 0; #1;
        chk("tgt_valid", if_valid_o, 1); chk("tgt_if_pc", if_pc_o, 32'h40);
        chk("c16_addr", imem_addr_o, 32'h44);

        @(negedge clk); trap_i = 1'b1; trap_vector_i = 32'h100;
        branch_taken_i = 1'b1; branch_target_i = 32'h80; #1;
        chk("trap_pri_en", pc_en_o, 1); chk("trap_pri_pc_in", pc_in_o, 32'h100);
        chk("trap_pri_mis", misalign_o, 0);
        @(negedge clk); trap_i = 1'b0; branch_taken_i = 1'b0; #1;
        chk("trap_addr", imem_addr_o, 32'h100); chk("trap_valid", if_valid_o, 0);

        @(negedge clk); branch_taken_i = 1'b1; branch_target_i = 32'h42; trap_vector_i = 32'h200; #1;
        chk("mis_pc_in", pc_in_o, mis_target); chk("mis_pulse", misalign_o, mis_pulse);
        chk("mis_if_pc", if_pc_o, 32'h100);
        @(negedge clk); branch_taken_i = 1'b0; trap_i = 1'b1; trap_vector_i = 32'h303; #1;
        chk("mis_addr", imem_addr_o, mis_target); chk("tvec_align", pc_in_o, 32'h300);
        chk("mis_clear", misalign_o, 0);

        @(negedge clk); trap_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC; #1;
        chk("tv_addr", imem_addr_o, 32'h300); chk("top_pc_in", pc_in_o, 32'hFFFF_FFFC);
        @(negedge clk); branch_taken_i = 1'b0; #1;
        chk("top_addr", imem_addr_o, 32'hFFFF_FFFC); chk("wrap_en", pc_en_o, 1);
        chk("wrap_pc_in", pc_in_o, 32'h0);

        @(negedge clk); if_ready_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h500; #1;
        chk("lowreq_req", imem_req_o, 0); chk("lowreq_en", pc_en_o, 1);
        chk("lowreq_pc_in", pc_in_o, 32'h500); chk("wrap_if_pc", if_pc_o, 32'hFFFF_FFFC);
        @(negedge clk); branch_taken_i = 1'b0; #1;
        chk("lowreq_valid", if_valid_o, 0); chk("lowreq_req2", imem_req_o, 1);
        chk("lowreq_addr", imem_addr_o, 32'h500);
        @(negedge clk); #1;
        chk("c25_valid", if_valid_o, 1); chk("c25_if_pc", if_pc_o, 32'h500); chk("c25_req", imem_req_o, 0);
        @(negedge clk); if_ready_i = 1'b1; #1;
        chk("c26_req", imem_req_o, 1); chk("c26_addr", imem_addr_o, 32'h504);

        @(negedge clk); rst = 1'b0; #1;                                   // mid-run reset
        chk("mrst_req", imem_req_o, 0); chk("mrst_en", pc_en_o, 0);
        chk("mrst_valid", if_valid_o, 0); chk("mrst_if_pc", if_pc_o, 0);
        chk("deliv_count", got_pc.size(), exp_pc.size());
        for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) chk("deliv_pc", got_pc[i], exp_pc[i]);
        @(negedge clk); @(negedge clk); rst = 1'b1; #1;
        chk("reboot_en", pc_en_o, 1); chk("reboot_req", imem_req_o, 0);
        @(negedge clk); #1;
        chk("reboot_req2", imem_req_o, 1); chk("reboot_addr", imem_addr_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
